// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared types and helpers for the alarm scheduler:
//   state_t   - scheduler FSM states (IDLE / RINGING / SNOOZED)
//   hms_t     - BCD hh:mm:ss, {hh_hi,hh_lo,mm_hi,mm_lo,ss_hi,ss_lo}
//   hm_t      - BCD hh:mm,    {hh_hi,hh_lo,mm_hi,mm_lo}
//   hm_valid  - 1 when every digit is legal and hh<=23, mm<=59
//   hms_valid - as hm_valid, plus ss<=59
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] hh_hi;
    logic [3:0] hh_lo;
    logic [3:0] mm_hi;
    logic [3:0] mm_lo;
    logic [3:0] ss_hi;
    logic [3:0] ss_lo;
  } hms_t;

  typedef struct packed {
    logic [3:0] hh_hi;
    logic [3:0] hh_lo;
    logic [3:0] mm_hi;
    logic [3:0] mm_lo;
  } hm_t;

  // Bounding the tens digits also rules out any digit above 9 in those places.
  function automatic logic hm_valid(input hm_t t);
    return (t.hh_hi <= 4'd2) &&
           (t.hh_lo <= 4'd9) &&
           !((t.hh_hi == 4'd2) && (t.hh_lo > 4'd3)) &&
           (t.mm_hi <= 4'd5) &&
           (t.mm_lo <= 4'd9);
  endfunction

  function automatic logic hms_valid(input hms_t t);
    return hm_valid(hm_t'(t[23:8])) &&
           (t.ss_hi <= 4'd5) &&
           (t.ss_lo <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// -----------------------------------------------------------------------------
// bcd_time_counter
// 24-hour BCD time-of-day register with second/minute/hour carry chain.
// Ports:
//   clk          - clock, all state on rising edge
//   i_reset_n    - asynchronous active-low reset, clears time to 00:00:00
//   i_tick       - advance by one second
//   i_load       - load i_load_time (takes priority over i_tick)
//   i_load_time  - BCD hh:mm:ss to load (assumed already validated)
//   o_time       - current registered time
//   o_time_inc   - current time plus one second (combinational), used by the
//                  parent to compare against alarms before the edge
// -----------------------------------------------------------------------------
module bcd_time_counter
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_tick,
  input  logic        i_load,
  input  logic [23:0] i_load_time,
  output logic [23:0] o_time,
  output logic [23:0] o_time_inc
);

  hms_t r_time;
  hms_t w_inc;
  logic w_ss_carry;
  logic w_mm_carry;

  always_comb begin
    w_inc      = r_time;
    w_ss_carry = 1'b0;
    w_mm_carry = 1'b0;

    // seconds
    if (r_time.ss_lo == 4'd9) begin
      w_inc.ss_lo = 4'd0;
      if (r_time.ss_hi == 4'd5) begin
        w_inc.ss_hi = 4'd0;
        w_ss_carry  = 1'b1;
      end else begin
        w_inc.ss_hi = r_time.ss_hi + 4'd1;
      end
    end else begin
      w_inc.ss_lo = r_time.ss_lo + 4'd1;
    end

    // minutes
    if (w_ss_carry) begin
      if (r_time.mm_lo == 4'd9) begin
        w_inc.mm_lo = 4'd0;
        if (r_time.mm_hi == 4'd5) begin
          w_inc.mm_hi = 4'd0;
          w_mm_carry  = 1'b1;
        end else begin
          w_inc.mm_hi = r_time.mm_hi + 4'd1;
        end
      end else begin
        w_inc.mm_lo = r_time.mm_lo + 4'd1;
      end
    end

    // hours: 23 wraps to 00, otherwise ordinary decimal carry
    if (w_mm_carry) begin
      if ((r_time.hh_hi == 4'd2) && (r_time.hh_lo == 4'd3)) begin
        w_inc.hh_hi = 4'd0;
        w_inc.hh_lo = 4'd0;
      end else if (r_time.hh_lo == 4'd9) begin
        w_inc.hh_lo = 4'd0;
        w_inc.hh_hi = r_time.hh_hi + 4'd1;
      end else begin
        w_inc.hh_lo = r_time.hh_lo + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_time <= '0;
    end else if (i_load) begin
      r_time <= hms_t'(i_load_time);
    end else if (i_tick) begin
      r_time <= w_inc;
    end
  end

  assign o_time     = r_time;
  assign o_time_inc = w_inc;

endmodule

// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
// Time-of-day clock with NUM_ALARMS programmable hh:mm alarm slots, a ringing
// timeout and a snooze function.
// Ports:
//   clk, reset_n  - clock / asynchronous active-low reset
//   tick          - 1 Hz one-cycle enable
//   set_valid     - load set_time (BCD hh:mm:ss) into the clock
//   alarm_wr      - write alarm_time (BCD hh:mm) into slot alarm_idx
//   alarm_en      - per-slot enable level
//   snooze        - user snooze request (effective while ringing)
//   dismiss       - user dismiss request (wins over snooze)
//   time_bcd      - current time, registered
//   ringing       - high in RINGING
//   ring_id       - slot that triggered the current ring/snooze
//   snoozed       - high in SNOOZED
//   set_err       - one-cycle pulse after an invalid set_valid/alarm_wr
// -----------------------------------------------------------------------------
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter  int NUM_ALARMS     = 4,
  parameter  int SNOOZE_MIN     = 5,
  parameter  int RING_TIMEOUT_S = 60,
  localparam int IDX_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  set_valid,
  input  logic [23:0]           set_time,
  input  logic                  alarm_wr,
  input  logic [IDX_W-1:0]      alarm_idx,
  input  logic [15:0]           alarm_time,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_bcd,
  output logic                  ringing,
  output logic [IDX_W-1:0]      ring_id,
  output logic                  snoozed,
  output logic                  set_err
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int SNZ_W        = $clog2(SNOOZE_TICKS + 1);
  localparam int TO_W         = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_TICKS);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(RING_TIMEOUT_S);

  logic                  w_set_ok;
  logic                  w_alarm_ok;
  logic                  w_tick_adv;
  logic [23:0]           w_time;
  logic [23:0]           w_time_inc;
  hm_t                   r_alarm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_slot_hit;
  logic                  w_hit_any;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_match;
  logic                  w_ring_en;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_ring_id;
  logic [IDX_W-1:0]      w_ring_id_next;
  logic [TO_W-1:0]       r_timeout;
  logic [TO_W-1:0]       w_timeout_next;
  logic [SNZ_W-1:0]      r_snooze;
  logic [SNZ_W-1:0]      w_snooze_next;
  logic                  r_set_err;

  // Invalid loads/writes are dropped entirely; only set_err reports them.
  assign w_set_ok   = set_valid && hms_valid(hms_t'(set_time));
  assign w_alarm_ok = alarm_wr && hm_valid(hm_t'(alarm_time));
  // A valid load in the same cycle swallows the tick for time keeping.
  assign w_tick_adv = tick && !w_set_ok;

  bcd_time_counter u_time (
    .clk         (clk),
    .i_reset_n   (reset_n),
    .i_tick      (w_tick_adv),
    .i_load      (w_set_ok),
    .i_load_time (set_time),
    .o_time      (w_time),
    .o_time_inc  (w_time_inc)
  );

  // Alarm slots. Matching compares against the time the clock is about to
  // show, so ringing rises on the same edge the new minute appears.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_alarm[gi] <= '0;
        end else if (w_alarm_ok && (alarm_idx == IDX_W'(gi))) begin
          r_alarm[gi] <= hm_t'(alarm_time);
        end
      end

      assign w_slot_hit[gi] = alarm_en[gi] &&
                              (r_alarm[gi] == hm_t'(w_time_inc[23:8])) &&
                              (w_time_inc[7:0] == 8'h00);
    end
  endgenerate

  // Lowest index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (w_slot_hit[k]) begin
        w_hit_any = 1'b1;
        w_hit_idx = IDX_W'(k);
      end
    end
  end

  assign w_match   = w_tick_adv && w_hit_any;
  assign w_ring_en = alarm_en[r_ring_id];

  always_comb begin
    w_state_next   = r_state;
    w_ring_id_next = r_ring_id;
    w_timeout_next = r_timeout;
    w_snooze_next  = r_snooze;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_next   = ST_RINGING;
          w_ring_id_next = w_hit_idx;
          w_timeout_next = TO_LOAD;
        end
      end
      ST_RINGING: begin
        if (!w_ring_en || dismiss) begin
          w_state_next   = ST_IDLE;
          w_timeout_next = '0;
        end else if (snooze) begin
          w_state_next   = ST_SNOOZED;
          w_snooze_next  = SNZ_LOAD;
          w_timeout_next = '0;
        end else if (tick) begin
          if (r_timeout <= TO_W'(1)) begin
            w_state_next   = ST_IDLE;
            w_timeout_next = '0;
          end else begin
            w_timeout_next = r_timeout - TO_W'(1);
          end
        end
      end
      ST_SNOOZED: begin
        // snooze is intentionally not looked at here
        if (!w_ring_en || dismiss) begin
          w_state_next  = ST_IDLE;
          w_snooze_next = '0;
        end else if (tick) begin
          if (r_snooze <= SNZ_W'(1)) begin
            w_state_next   = ST_RINGING;
            w_snooze_next  = '0;
            w_timeout_next = TO_LOAD;
          end else begin
            w_snooze_next = r_snooze - SNZ_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ring_id <= '0;
      r_timeout <= '0;
      r_snooze  <= '0;
      r_set_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ring_id <= w_ring_id_next;
      r_timeout <= w_timeout_next;
      r_snooze  <= w_snooze_next;
      r_set_err <= (set_valid && !hms_valid(hms_t'(set_time))) ||
                   (alarm_wr && !hm_valid(hm_t'(alarm_time)));
    end
  end

  assign time_bcd = w_time;
  assign ringing  = (r_state == ST_RINGING);
  assign snoozed  = (r_state == ST_SNOOZED);
  assign ring_id  = r_ring_id;
  assign set_err  = r_set_err;

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
// Scoreboard bench: each driven cycle steps a seconds-since-midnight reference
// model and queues the expected outputs; a monitor compares them after the
// edge. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;

  localparam int NA    = 4;
  localparam int SZMIN = 5;
  localparam int TO_S  = 60;
  localparam int SNZ_T = SZMIN * 60;
  localparam int DAY   = 86400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick, set_valid, alarm_wr, snooze, dismiss;
  logic [23:0] set_time;
  logic [1:0]  alarm_idx;
  logic [15:0] alarm_time;
  logic [3:0]  alarm_en;
  logic [23:0] time_bcd;
  logic        ringing, snoozed, set_err;
  logic [1:0]  ring_id;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .NUM_ALARMS     (NA),
    .SNOOZE_MIN     (SZMIN),
    .RING_TIMEOUT_S (TO_S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .set_valid  (set_valid),
    .set_time   (set_time),
    .alarm_wr   (alarm_wr),
    .alarm_idx  (alarm_idx),
    .alarm_time (alarm_time),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .time_bcd   (time_bcd),
    .ringing    (ringing),
    .ring_id    (ring_id),
    .snoozed    (snoozed),
    .set_err    (set_err)
  );

  typedef struct {
    logic [23:0] t;
    logic        ring;
    logic        snz;
    logic [1:0]  id;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // stimulus shadow for the next driven cycle
  bit          s_tick, s_set_valid, s_alarm_wr, s_snooze, s_dismiss;
  logic [23:0] s_set_time;
  logic [1:0]  s_alarm_idx;
  logic [15:0] s_alarm_time;
  logic [3:0]  s_en;

  // reference model: time in seconds, alarms in minutes of day
  int m_secs;
  int m_alarm_min [NA];
  int m_mode;   // 0 idle, 1 ringing, 2 snoozed
  int m_id;
  int m_to;
  int m_sz;
  bit m_err;

  function automatic bit bcd_ok(input logic [23:0] v, input bit with_ss);
    int d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    return ((d[5]*10 + d[4]) < 24) && ((d[3]*10 + d[2]) < 60) &&
           (!with_ss || ((d[1]*10 + d[0]) < 60));
  endfunction

  function automatic int bcd_secs(input logic [23:0] v);
    int hh, mm, ss;
    hh = int'(v[23:20]) * 10 + int'(v[19:16]);
    mm = int'(v[15:12]) * 10 + int'(v[11:8]);
    ss = int'(v[7:4]) * 10 + int'(v[3:0]);
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic logic [23:0] secs_bcd(input int s);
    int hh, mm, ss;
    hh = s / 3600;
    mm = (s / 60) % 60;
    ss = s % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic note(input string s);
    $display("txn %0t %s", $time, s);
  endtask

  task automatic model_reset();
    m_secs = 0;
    for (int k = 0; k < NA; k++) m_alarm_min[k] = 0;
    m_mode = 0;
    m_id   = 0;
    m_to   = 0;
    m_sz   = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    bit set_ok, adv, err_n;
    int nt, hit;
    set_ok = s_set_valid && bcd_ok(s_set_time, 1'b1);
    err_n  = (s_set_valid && !set_ok) ||
             (s_alarm_wr && !bcd_ok({s_alarm_time, 8'h00}, 1'b0));
    adv    = s_tick && !set_ok;
    nt     = (m_secs + 1) % DAY;
    hit    = -1;
    if (adv && (nt % 60 == 0)) begin
      for (int k = 0; k < NA; k++)
        if (hit < 0 && s_en[k] && (m_alarm_min[k] * 60 == nt)) hit = k;
    end
    case (m_mode)
      0: if (hit >= 0) begin m_mode = 1; m_id = hit; m_to = TO_S; end
      1: begin
        if (!s_en[m_id] || s_dismiss) m_mode = 0;
        else if (s_snooze) begin m_mode = 2; m_sz = SNZ_T; end
        else if (s_tick) begin
          m_to--;
          if (m_to == 0) m_mode = 0;
        end
      end
      default: begin
        if (!s_en[m_id] || s_dismiss) m_mode = 0;
        else if (s_tick) begin
          m_sz--;
          if (m_sz == 0) begin m_mode = 1; m_to = TO_S; end
        end
      end
    endcase
    if (set_ok) m_secs = bcd_secs(s_set_time);
    else if (adv) m_secs = nt;
    if (s_alarm_wr && bcd_ok({s_alarm_time, 8'h00}, 1'b0))
      m_alarm_min[s_alarm_idx] = bcd_secs({s_alarm_time, 8'h00}) / 60;
    m_err = err_n;
  endtask

  // Drive one cycle of stimulus, predict its result, queue the expectation.
  task automatic step();
    exp_t e;
    @(negedge clk);
    tick       = s_tick;
    set_valid  = s_set_valid;
    set_time   = s_set_time;
    alarm_wr   = s_alarm_wr;
    alarm_idx  = s_alarm_idx;
    alarm_time = s_alarm_time;
    alarm_en   = s_en;
    snooze     = s_snooze;
    dismiss    = s_dismiss;
    model_step();
    e.t    = secs_bcd(m_secs);
    e.ring = (m_mode == 1);
    e.snz  = (m_mode == 2);
    e.id   = 2'(m_id);
    e.err  = m_err;
    exp_q.push_back(e);
    s_tick = 0; s_set_valid = 0; s_alarm_wr = 0; s_snooze = 0; s_dismiss = 0;
  endtask

  task automatic quiet();
    tick = 0; set_valid = 0; alarm_wr = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      s_tick = 1;
      step();
    end
  endtask

  task automatic set_clock(input logic [23:0] v);
    s_set_valid = 1;
    s_set_time  = v;
    note($sformatf("set_time %h tick=%0d", v, s_tick));
    step();
  endtask

  task automatic wr_alarm(input logic [1:0] idx, input logic [15:0] v);
    s_alarm_wr   = 1;
    s_alarm_idx  = idx;
    s_alarm_time = v;
    note($sformatf("alarm_wr slot=%0d time=%h", idx, v));
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_time"},    32'(time_bcd), 32'h0);
    chk({tag, "_ringing"}, 32'(ringing),  32'h0);
    chk({tag, "_snoozed"}, 32'(snoozed),  32'h0);
    chk({tag, "_ring_id"}, 32'(ring_id),  32'h0);
    chk({tag, "_set_err"}, 32'(set_err),  32'h0);
  endtask

  // monitor: one expectation per driven cycle, compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_time",    32'(time_bcd), 32'(e.t));
        chk("sb_ringing", 32'(ringing),  32'(e.ring));
        chk("sb_snoozed", 32'(snoozed),  32'(e.snz));
        chk("sb_ring_id", 32'(ring_id),  32'(e.id));
        chk("sb_set_err", 32'(set_err),  32'(e.err));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pool_min [NA] = '{450, 451, 1439, 0};

  initial begin
    int r, pm;
    reset_n = 0;
    quiet();
    set_time = '0; alarm_idx = '0; alarm_time = '0; alarm_en = '0;
    s_tick = 0; s_set_valid = 0; s_alarm_wr = 0; s_snooze = 0; s_dismiss = 0;
    s_set_time = '0; s_alarm_idx = '0; s_alarm_time = '0; s_en = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1;

    // first tick after reset release
    note("first tick after reset");
    do_ticks(1); settle();
    chk("first_tick", 32'(time_bcd), 32'h000001);

    // midnight wrap
    set_clock(24'h235958);
    do_ticks(1); settle();
    chk("wrap_235959", 32'(time_bcd), 32'h235959);
    do_ticks(1); settle();
    chk("wrap_000000", 32'(time_bcd), 32'h000000);

    // load and tick together: load wins
    s_tick = 1;
    set_clock(24'h120000); settle();
    chk("load_wins", 32'(time_bcd), 32'h120000);

    // two slots match: lowest index
    wr_alarm(2'd0, 16'h0730);
    wr_alarm(2'd2, 16'h0730);
    s_en = 4'b0101;
    set_clock(24'h072959);
    do_ticks(1); settle();
    chk("match_ringing", 32'(ringing), 32'h1);
    chk("match_ring_id", 32'(ring_id), 32'h0);

    // snooze for 300 ticks, then ring again
    note("snooze");
    s_snooze = 1; step(); settle();
    chk("snooze_entered", 32'(snoozed), 32'h1);
    do_ticks(SNZ_T - 1); settle();
    chk("snooze_not_yet", 32'(snoozed), 32'h1);
    do_ticks(1); settle();
    chk("snooze_reringing", 32'(ringing), 32'h1);
    chk("snooze_same_id", 32'(ring_id), 32'h0);

    // unattended timeout
    do_ticks(TO_S - 1); settle();
    chk("timeout_not_yet", 32'(ringing), 32'h1);
    do_ticks(1); settle();
    chk("timeout_idle", 32'(ringing), 32'h0);

    // snooze + dismiss together
    set_clock(24'h072959);
    do_ticks(1);
    note("snooze+dismiss");
    s_snooze = 1; s_dismiss = 1; step(); settle();
    chk("dismiss_prio_ring", 32'(ringing), 32'h0);
    chk("dismiss_prio_snz",  32'(snoozed), 32'h0);

    // rewrite ringing slot keeps ringing; dropping its enable stops it
    set_clock(24'h072959);
    do_ticks(1);
    wr_alarm(2'd0, 16'h0800); settle();
    chk("wr_ring_slot", 32'(ringing), 32'h1);
    note("disable ringing slot");
    s_en = 4'b0100; step(); settle();
    chk("en_drop_idle", 32'(ringing), 32'h0);

    // a match arriving while ringing is ignored
    wr_alarm(2'd1, 16'h0801);
    s_en = 4'b0011;
    set_clock(24'h075959);
    do_ticks(1);
    do_ticks(TO_S); settle();
    chk("match_ignored", 32'(ringing), 32'h0);

    // invalid loads
    set_clock(24'h240000); settle();
    chk("err_hh24", 32'(set_err), 32'h1);
    chk("err_hh24_time", 32'(time_bcd), 32'h080100);
    step(); settle();
    chk("err_one_cycle", 32'(set_err), 32'h0);
    set_clock(24'h120A00); settle();
    chk("err_mmA", 32'(set_err), 32'h1);
    chk("err_mmA_time", 32'(time_bcd), 32'h080100);
    wr_alarm(2'd3, 16'h2360); settle();
    chk("err_alarm", 32'(set_err), 32'h1);

    // asynchronous reset while snoozed
    s_en = 4'b0001;
    set_clock(24'h075959);
    do_ticks(1);
    s_snooze = 1; step();
    do_ticks(10); settle();
    chk("pre_reset_snoozed", 32'(snoozed), 32'h1);
    quiet();
    #2 reset_n = 0;
    note("async reset while snoozed");
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    model_reset();
    s_en = '0;
    alarm_en = '0;
    @(negedge clk);
    reset_n = 1;

    // randomized phase
    for (int k = 0; k < NA; k++) wr_alarm(2'(k), secs_bcd(pool_min[k] * 60)[23:8]);
    s_en = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      s_tick = ($urandom_range(0, 1) == 1);
      if (r < 3) begin
        s_tick = 0;
        if ($urandom_range(0, 4) == 0) begin
          set_clock({4'($urandom_range(3, 15)), 20'($urandom)});
        end else begin
          pm = pool_min[$urandom_range(0, NA - 1)];
          set_clock(secs_bcd((pm * 60 - int'($urandom_range(1, 4)) + DAY) % DAY));
        end
      end else if (r < 6) begin
        if ($urandom_range(0, 4) == 0)
          wr_alarm(2'($urandom_range(0, 3)), {4'h2, 4'($urandom_range(4, 15)), 8'h00});
        else
          wr_alarm(2'($urandom_range(0, 3)),
                   secs_bcd(pool_min[$urandom_range(0, NA - 1)] * 60)[23:8]);
      end else if (r < 10) begin
        s_snooze = 1;
        note("snooze");
        step();
      end else if (r < 12) begin
        s_dismiss = 1;
        note("dismiss");
        step();
      end else if (r < 13) begin
        s_en = 4'($urandom);
        note($sformatf("alarm_en %b", s_en));
        step();
      end else begin
        step();
      end
    end

    settle();
    quiet();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
